// File: rtl/irda_wb_initiator.sv
// Single-transaction Wishbone initiator for the IrDA register space.
// One classic Wishbone cycle per command, with UART-map narrowing and an ack timeout.
module irda_wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        fast_mode,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_addr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          bus_q, bus_d;
  logic          we_q, we_d;
  logic [3:0]    addr_q, addr_d;
  logic [31:0]   dat_q, dat_d;
  logic          timeout_hit;

  // This BUS cycle is the TIMEOUT-th one spent waiting.
  assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    bus_d       = bus_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dat_d       = dat_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          mode_d      = fast_mode;
          we_d        = cmd_we;
          addr_d      = fast_mode ? cmd_addr : {1'b0, cmd_addr[2:0]};
          dat_d       = fast_mode ? cmd_dat : {24'b0, cmd_dat[7:0]};
          bus_d       = 1'b1;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = BUS;
        end
      end

      BUS: begin
        if (wb_ack_i || timeout_hit) begin
          bus_d       = 1'b0;
          we_d        = 1'b0;
          addr_d      = '0;
          dat_d       = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          // Ack takes priority over a timeout landing on the same edge.
          if (wb_ack_i) begin
            rsp_err_d = 1'b0;
            if (we_q)        rsp_dat_d = '0;
            else if (mode_q) rsp_dat_d = wb_dat_i;
            else             rsp_dat_d = {24'b0, wb_dat_i[7:0]};
          end else begin
            rsp_err_d = 1'b1;
            rsp_dat_d = '0;
          end
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      bus_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      bus_q       <= bus_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wb_cyc_o  = bus_q;
  assign wb_stb_o  = bus_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_irda_wb_initiator.sv
// Bench for irda_wb_initiator: directed scenarios plus randomized commands
// checked against a transaction-level model of the initiator.
module tb_irda_wb_initiator;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fast_mode, cmd_valid, cmd_we, rsp_ready, wb_ack_i;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_dat, wb_dat_i;
  logic        cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rsp_dat, wb_dat_o;
  logic [3:0]  wb_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irda_wb_initiator #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .fast_mode(fast_mode),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_dat(cmd_dat), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  // One full command: accept, bus cycle with slave acking after `delay` waits
  // (never if delay >= TO), optional response backpressure, then hand-off.
  task automatic run_txn(input logic we, input logic [3:0] addr, input logic [31:0] dat,
                         input logic mode, input int delay, input logic [31:0] rd,
                         input int hold, input logic stray);
    int          stb_cnt, guard, exp_len;
    logic [3:0]  exp_addr;
    logic [31:0] exp_wdat, exp_rdat;
    logic        exp_err;
    exp_addr = mode ? addr : {1'b0, addr[2:0]};
    exp_wdat = mode ? dat : {24'b0, dat[7:0]};
    exp_err  = (delay + 1) > int'(TO);
    exp_len  = exp_err ? int'(TO) : delay + 1;
    exp_rdat = (exp_err || we) ? 32'h0 : (mode ? rd : {24'b0, rd[7:0]});

    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_idle got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_dat = dat; fast_mode = mode;
    wb_dat_i = rd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; fast_mode = ~mode; cmd_dat = ~dat; cmd_addr = ~addr; cmd_we = ~we;

    stb_cnt = 0;
    for (guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (wb_stb_o) begin
        stb_cnt++;
        checks++;
        if ({wb_cyc_o, wb_we_o, wb_addr_o, wb_dat_o, cmd_ready} !== {1'b1, we, exp_addr, exp_wdat, 1'b0}) begin
          errors++;
          $display("FAIL bus_fields got cyc=%b we=%b a=%h d=%h rdy=%b want 1 %b %h %h 0",
                   wb_cyc_o, wb_we_o, wb_addr_o, wb_dat_o, cmd_ready, we, exp_addr, exp_wdat);
        end
        wb_ack_i = (stb_cnt == delay + 1);
      end else begin
        wb_ack_i = 1'b0;
      end
    end
    wb_ack_i = 1'b0;
    checks++;
    if (guard >= 100) begin
      errors++; $display("FAIL rsp_timeout no rsp_valid within 100 cycles");
    end
    checks++;
    if (stb_cnt != exp_len) begin
      errors++; $display("FAIL stb_len got %0d want %0d", stb_cnt, exp_len);
    end
    checks++;
    if ({rsp_dat, rsp_err} !== {exp_rdat, exp_err}) begin
      errors++; $display("FAIL rsp got dat=%h err=%b want %h %b", rsp_dat, rsp_err, exp_rdat, exp_err);
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, cmd_ready} !== 39'h0) begin
      errors++;
      $display("FAIL bus_dropped got cyc=%b stb=%b we=%b a=%h d=%h rdy=%b want all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, cmd_ready);
    end

    for (int i = 0; i < hold; i++) begin
      wb_ack_i = stray && (i == 1);
      wb_dat_i = ~rd;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, wb_cyc_o} !== {1'b1, exp_rdat, exp_err, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rsp_hold got v=%b d=%h e=%b rdy=%b cyc=%b want 1 %h %b 0 0",
                 rsp_valid, rsp_dat, rsp_err, cmd_ready, wb_cyc_o, exp_rdat, exp_err);
      end
    end
    wb_ack_i  = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL rsp_handoff got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b v=%b e=%b cyc=%b stb=%b we=%b want 1 0 0 0 0 0",
               cmd_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o);
    end
    checks++;
    if ({rsp_dat, wb_addr_o, wb_dat_o} !== 68'h0) begin
      errors++; $display("FAIL reset_data got rd=%h a=%h wd=%h want 0", rsp_dat, wb_addr_o, wb_dat_o);
    end
  endtask

  task automatic test_fast_write();
    run_txn(1'b1, 4'hA, 32'hDEADBEEF, 1'b1, 2, 32'hCAFEF00D, 0, 1'b0);
  endtask

  task automatic test_uart_read();
    run_txn(1'b0, 4'hD, 32'hFFFF_FF11, 1'b0, 0, 32'h123456A5, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 4'h3, 32'h0, 1'b1, 1000, 32'h55AA55AA, 0, 1'b0);
    run_txn(1'b0, 4'h6, 32'h0, 1'b1, 1, 32'h0BADCAFE, 0, 1'b0);
  endtask

  task automatic test_ack_expiry();
    run_txn(1'b0, 4'h9, 32'h0, 1'b1, int'(TO) - 1, 32'h0000_0077, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 4'hC, 32'h0, 1'b1, 1, 32'h8765_4321, 5, 1'b1);
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h2; cmd_dat = 32'h11; fast_mode = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL mid_bus_reset got cyc=%b stb=%b v=%b rdy=%b want 0 0 0 1",
                         wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      wb_ack_i = i[0];
      @(negedge clk);
      checks++;
      if ({rsp_valid, wb_cyc_o} !== 2'b00) begin
        errors++; $display("FAIL aborted_rsp got v=%b cyc=%b want 0 0", rsp_valid, wb_cyc_o);
      end
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 4'($urandom), $urandom, 1'($urandom),
              int'($urandom_range(0, TO + 1)), $urandom, int'($urandom_range(0, 3)),
              1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      run_txn(1'(n), 4'(n * 5), $urandom, 1'(n >> 1), 0, $urandom, 0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; fast_mode = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_dat = '0; rsp_ready = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
    test_reset();
    test_fast_write();
    test_uart_read();
    test_timeout();
    test_ack_expiry();
    test_backpressure();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irda_wb_initiator.md
# irda_wb_initiator

Single-transaction Wishbone bus initiator for the IrDA core's register space: the master-side counterpart of the core's Wishbone slave router. It accepts register read/write commands on a valid/ready interface and runs one classic Wishbone cycle per command. It returns read data or write completion on a valid/ready response interface, with a bounded ack timeout. The initiator narrows commands to the UART register map (8-bit data, 3-bit address) when fast mode is off, and passes full 32-bit / 4-bit accesses when it is on.

## Interface
- TIMEOUT, 255: maximum BUS-state cycles spent waiting for `wb_ack_i`; legal range 1..65535.

- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- fast_mode  in  1  1 = fast-IR register map (32-bit); 0 = UART map (8-bit); sampled at command accept
- cmd_valid  in  1  command present
- cmd_ready  out  1  initiator can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  4  register address
- cmd_dat  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  1 = cycle timed out
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_addr_o  out  4  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

## Operation
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- Reset: state IDLE. `cmd_ready`=1, `rsp_valid`=0, `rsp_dat`=0, `rsp_err`=0, `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_addr_o`=0, `wb_dat_o`=0, timeout counter 0.
- IDLE: `cmd_ready`=1. When `cmd_valid & cmd_ready` at an edge:
  - Latch `cmd_we`, address, data and `fast_mode` into `mode_q`.
  - Go to BUS with `cmd_ready`=0 and `wb_cyc_o`=`wb_stb_o`=1.
- Narrowing at accept:
  - `mode_q`=1: `wb_addr_o`=`cmd_addr`, `wb_dat_o`=`cmd_dat`.
  - `mode_q`=0: `wb_addr_o`={1'b0, `cmd_addr[2:0]`}, `wb_dat_o`={24'b0, `cmd_dat[7:0]`}.
  - `wb_we_o`=`cmd_we`.
- BUS: `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_addr_o` and `wb_dat_o` stay stable. The counter increments each BUS cycle and is cleared on BUS entry.
  - `wb_ack_i`=1 at an edge:
    - Drop `wb_cyc_o`/`wb_stb_o`/`wb_we_o` and go to RESP with `rsp_err`=0.
    - `rsp_dat` = `wb_dat_i` for a read with `mode_q`=1, {24'b0, `wb_dat_i[7:0]`} for a read with `mode_q`=0, and 0 for a write.
  - Counter reaches TIMEOUT with no ack: drop the cycle and go to RESP with `rsp_err`=1, `rsp_dat`=0.
  - Ack in the same cycle as timeout expiry: ack wins, `rsp_err`=0.
- RESP: `rsp_valid`=1, with `rsp_dat`/`rsp_err` held stable, until `rsp_ready`=1 at an edge. Then `rsp_valid`=0, `cmd_ready`=1 and state returns to IDLE.
- `wb_ack_i` outside BUS is ignored. A `fast_mode` change after accept does not affect the in-flight command.
- `wb_addr_o`/`wb_dat_o` return to 0 when the cycle drops.
- Reset mid-operation (any state): all outputs take their reset values at the next edge. A pending response is discarded and the bus cycle is abandoned.

## Timing
- Accept at edge E0 → `wb_cyc_o`/`wb_stb_o` high from E0 to E1 at the earliest.
- Ack sampled at edge Ea → cycle low and `rsp_valid` high after Ea.
  - Zero-wait slave (ack high on the first BUS cycle): `wb_stb_o` high for exactly 1 clock.
- Max `wb_stb_o` duration is TIMEOUT clocks. An error response appears after edge E0+TIMEOUT.
- `rsp_ready` held high: `cmd_ready` returns 1 clock after `rsp_valid` rises.
  - Peak throughput: 1 command per 3 clocks with a zero-wait slave.
- Commands are never accepted while in BUS or RESP; there is no queueing.
- Counter width: enough to hold TIMEOUT, saturating, with no wrap.

## Test plan
- Fast write: `fast_mode`=1, cmd write addr 4'hA data 32'hDEADBEEF, slave acks after 2 waits → `wb_addr_o`=4'hA, `wb_dat_o`=32'hDEADBEEF, `wb_we_o`=1 for 3 clocks. Response `rsp_dat`=0, `rsp_err`=0.
- UART read narrowing: `fast_mode`=0, cmd read addr 4'hD, slave returns 32'h123456A5 with zero wait → `wb_addr_o`=4'h5, `wb_stb_o` high 1 clock, `rsp_dat`=32'h000000A5.
- Timeout: TIMEOUT=4, no ack → `wb_stb_o` high exactly 4 clocks, then `rsp_err`=1, `rsp_dat`=0. A subsequent command is accepted normally.
- Ack on the expiry cycle: TIMEOUT=4, ack on the 4th BUS cycle with read data 32'h0000_0077 in fast mode → `rsp_err`=0, `rsp_dat`=32'h77.
- Response backpressure: hold `rsp_ready`=0 for 5 clocks → `rsp_valid`, `rsp_dat` and `rsp_err` stable, `cmd_ready`=0 throughout. A stray `wb_ack_i` pulse is ignored.
- Reset mid-BUS: assert `wb_rst_i` on the 2nd BUS cycle → `wb_cyc_o`=0, `rsp_valid`=0, `cmd_ready`=1 after that edge. No response is ever emitted for the aborted command.
